// File: rtl/ibex_crypto_key_ctrl_pkg.sv
// Shared types and constants for the AES key-load controller.
// State and error encodings are visible to software through the STATUS register.
package ibex_crypto_key_ctrl_pkg;

  typedef enum logic [2:0] {
    KC_IDLE   = 3'd0,
    KC_DRAIN  = 3'd1,
    KC_LOAD   = 3'd2,
    KC_ACTIVE = 3'd3,
    KC_ERROR  = 3'd4
  } key_ctrl_state_e;

  typedef enum logic [1:0] {
    KC_ERR_NONE       = 2'd0,
    KC_ERR_INCOMPLETE = 2'd1,
    KC_ERR_TIMEOUT    = 2'd2,
    KC_ERR_FAULT      = 2'd3
  } key_ctrl_err_e;

  localparam logic [2:0] KEY_CTRL_ADDR_CTRL = 3'd4;

  localparam int KEY_CTRL_BIT_COMMIT  = 0;
  localparam int KEY_CTRL_BIT_CLEAR   = 1;
  localparam int KEY_CTRL_BIT_CLR_ERR = 2;

endpackage

// File: rtl/ibex_crypto_key_ctrl.sv
// AES key-load sequencer: stages a 128-bit key from CSR writes, drains the secure
// ALU, swaps the active key, and handles clear, drain timeout and ALU faults.
//
// state  | meaning
// IDLE   | no key loaded
// DRAIN  | commit accepted, waiting for the secure ALU to go idle
// LOAD   | new key installed, valid held low for one cycle
// ACTIVE | key loaded and usable
// ERROR  | fault latched, key zeroised, left only by CLR_ERR
module ibex_crypto_key_ctrl
  import ibex_crypto_key_ctrl_pkg::*;
#(
  parameter int TimeoutCycles = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         csr_we_i,
  input  logic [2:0]   csr_addr_i,
  input  logic [31:0]  csr_wdata_i,
  output logic [31:0]  csr_rdata_o,
  output logic [127:0] aes_key_o,
  output logic         aes_key_valid_o,
  input  logic         crypto_busy_i,
  input  logic         crypto_error_i,
  output logic         ex_stall_o,
  output logic         key_err_o
);

  localparam int CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  key_ctrl_state_e   r_state, w_state_n, w_state_seen;
  key_ctrl_err_e     r_err, w_err_n;
  logic [3:0][31:0]  r_shadow, w_shadow_n;
  logic [3:0]        r_mask, w_mask_n;
  logic [127:0]      r_key, w_key_n;
  logic              r_valid, w_valid_n;
  logic [CntW-1:0]   r_cnt, w_cnt_n;

  logic w_ctrl_we, w_key_we;

  assign w_ctrl_we = csr_we_i && (csr_addr_i == KEY_CTRL_ADDR_CTRL);
  assign w_key_we  = csr_we_i && (csr_addr_i[2] == 1'b0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= KC_IDLE;
      r_err    <= KC_ERR_NONE;
      r_shadow <= '0;
      r_mask   <= '0;
      r_key    <= '0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_err    <= w_err_n;
      r_shadow <= w_shadow_n;
      r_mask   <= w_mask_n;
      r_key    <= w_key_n;
      r_valid  <= w_valid_n;
      r_cnt    <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_err_n      = r_err;
    w_shadow_n   = r_shadow;
    w_mask_n     = r_mask;
    w_key_n      = r_key;
    w_valid_n    = r_valid;
    w_cnt_n      = r_cnt;
    w_state_seen = r_state;

    case (r_state)
      KC_DRAIN: begin
        if (!crypto_busy_i) begin
          w_key_n    = r_shadow;
          w_valid_n  = 1'b0;
          w_shadow_n = '0;
          w_mask_n   = '0;
          w_state_n  = KC_LOAD;
        end else if (r_cnt == CntLast) begin
          w_err_n    = KC_ERR_TIMEOUT;
          w_key_n    = '0;
          w_shadow_n = '0;
          w_mask_n   = '0;
          w_valid_n  = 1'b0;
          w_state_n  = KC_ERROR;
        end else begin
          w_cnt_n = r_cnt + CntW'(1);
        end
      end
      KC_LOAD: begin
        w_valid_n = 1'b1;
        w_state_n = KC_ACTIVE;
      end
      default: ;
    endcase

    // A fault overrides everything else; CTRL bits otherwise apply in priority order,
    // each seeing the state left by the one before it.
    if (crypto_error_i) begin
      w_err_n    = KC_ERR_FAULT;
      w_key_n    = '0;
      w_shadow_n = '0;
      w_mask_n   = '0;
      w_valid_n  = 1'b0;
      w_state_n  = KC_ERROR;
    end else begin
      if (w_ctrl_we && csr_wdata_i[KEY_CTRL_BIT_CLR_ERR]) begin
        if (w_state_seen == KC_ERROR) begin
          w_err_n      = KC_ERR_NONE;
          w_state_n    = KC_IDLE;
          w_state_seen = KC_IDLE;
        end else if (w_err_n == KC_ERR_INCOMPLETE) begin
          w_err_n = KC_ERR_NONE;
        end
      end
      if (w_ctrl_we && csr_wdata_i[KEY_CTRL_BIT_CLEAR]) begin
        w_key_n    = '0;
        w_shadow_n = '0;
        w_mask_n   = '0;
        w_valid_n  = 1'b0;
        if (w_state_n != KC_ERROR) begin
          w_state_n    = KC_IDLE;
          w_state_seen = KC_IDLE;
        end
      end
      if (w_ctrl_we && csr_wdata_i[KEY_CTRL_BIT_COMMIT] &&
          (w_state_seen == KC_IDLE || w_state_seen == KC_ACTIVE)) begin
        if (w_mask_n == 4'hF) begin
          w_state_n = KC_DRAIN;
          w_cnt_n   = '0;
        end else begin
          w_err_n = KC_ERR_INCOMPLETE;
        end
      end
      if (w_key_we && (w_state_seen == KC_IDLE || w_state_seen == KC_ACTIVE)) begin
        w_shadow_n[csr_addr_i[1:0]] = csr_wdata_i;
        w_mask_n[csr_addr_i[1:0]]   = 1'b1;
      end
    end
  end

  assign aes_key_o       = r_key;
  assign aes_key_valid_o = r_valid;
  assign ex_stall_o      = (r_state == KC_DRAIN) || (r_state == KC_LOAD);
  assign key_err_o       = (r_err != KC_ERR_NONE);

  // Key material never leaves through the CSR port.
  assign csr_rdata_o = (csr_addr_i == KEY_CTRL_ADDR_CTRL) ?
                       {21'b0, r_state, r_err, r_mask, 1'b0, r_valid} : 32'b0;

endmodule

// File: tb/tb_ibex_crypto_key_ctrl.sv
// Bench for the AES key-load sequencer: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the key controller.
module tb_ibex_crypto_key_ctrl;
  import ibex_crypto_key_ctrl_pkg::*;

  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst, we, busy, cerr;
  logic [2:0]   addr;
  logic [31:0]  wdata, rdata;
  logic [127:0] key;
  logic         valid, stall, kerr;

  ibex_crypto_key_ctrl #(.TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .csr_we_i(we), .csr_addr_i(addr),
    .csr_wdata_i(wdata), .csr_rdata_o(rdata), .aes_key_o(key),
    .aes_key_valid_o(valid), .crypto_busy_i(busy), .crypto_error_i(cerr),
    .ex_stall_o(stall), .key_err_o(kerr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the key controller seen as a few named facts.
  key_ctrl_state_e m_st;
  key_ctrl_err_e   m_err;
  logic [31:0]     m_sh[4];
  logic [31:0]     m_key[4];
  bit              m_have[4];
  bit              m_valid;
  int              m_wait;

  function automatic void wipe_all();
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = 0; m_key[i] = 0; m_have[i] = 0;
    end
    m_valid = 0;
  endfunction

  function automatic void model_reset();
    wipe_all();
    m_st = KC_IDLE; m_err = KC_ERR_NONE; m_wait = 0;
  endfunction

  function automatic bit all_staged();
    return m_have[0] && m_have[1] && m_have[2] && m_have[3];
  endfunction

  task automatic model_step();
    bit ctrl, kw, open_st;
    key_ctrl_state_e seen;
    if (rst) begin model_reset(); return; end
    ctrl = we && (addr == 3'd4);
    kw   = we && (addr < 3'd4);
    seen = m_st;
    if (m_st == KC_DRAIN) begin
      if (!busy) begin
        for (int i = 0; i < 4; i++) begin
          m_key[i] = m_sh[i]; m_sh[i] = 0; m_have[i] = 0;
        end
        m_valid = 0; m_st = KC_LOAD;
      end else if (m_wait == TO - 1) begin
        wipe_all(); m_err = KC_ERR_TIMEOUT; m_st = KC_ERROR;
      end else m_wait++;
    end else if (m_st == KC_LOAD) begin
      m_valid = 1; m_st = KC_ACTIVE;
    end
    if (cerr) begin
      wipe_all(); m_err = KC_ERR_FAULT; m_st = KC_ERROR; return;
    end
    if (ctrl && wdata[2]) begin
      if (seen == KC_ERROR) begin m_err = KC_ERR_NONE; m_st = KC_IDLE; seen = KC_IDLE; end
      else if (m_err == KC_ERR_INCOMPLETE) m_err = KC_ERR_NONE;
    end
    if (ctrl && wdata[1]) begin
      wipe_all();
      if (m_st != KC_ERROR) begin m_st = KC_IDLE; seen = KC_IDLE; end
    end
    open_st = (seen == KC_IDLE) || (seen == KC_ACTIVE);
    if (ctrl && wdata[0] && open_st) begin
      if (all_staged()) begin m_st = KC_DRAIN; m_wait = 0; end
      else m_err = KC_ERR_INCOMPLETE;
    end
    if (kw && open_st) begin
      m_sh[addr[1:0]] = wdata; m_have[addr[1:0]] = 1;
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [3:0] mk;
    mk = {m_have[3], m_have[2], m_have[1], m_have[0]};
    return {21'b0, m_st, m_err, mk, 1'b0, m_valid};
  endfunction

  task automatic compare_all();
    logic [127:0] ek;
    ek = {m_key[3], m_key[2], m_key[1], m_key[0]};
    check("key", key, ek);
    check("valid", valid, m_valid);
    check("stall", stall, (m_st == KC_DRAIN) || (m_st == KC_LOAD));
    check("key_err", kerr, m_err != KC_ERR_NONE);
    check("rdata", rdata, (addr == 3'd4) ? m_status() : 32'h0);
  endtask

  task automatic cyc(input logic r, input logic w, input logic [2:0] a,
                     input logic [31:0] d, input logic e);
    rst = r; we = w; addr = a; wdata = d; cerr = e;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd4, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic load4(input logic [31:0] w0, w1, w2, w3);
    wr(3'd0, w0); wr(3'd1, w1); wr(3'd2, w2); wr(3'd3, w3);
  endtask

  localparam logic [31:0] C_COMMIT  = 32'h1;
  localparam logic [31:0] C_CLEAR   = 32'h2;
  localparam logic [31:0] C_CLR_ERR = 32'h4;

  initial begin
    int n;
    logic [127:0] key_a, key_b;
    rst = 1'b1; we = 1'b0; addr = 3'd4; wdata = 32'h0; busy = 1'b0; cerr = 1'b0;
    model_reset();
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 1'b0);
    idle();
    check("reset_status", rdata, 32'h0);

    // Normal load
    load4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    wr(3'd4, C_COMMIT);
    check("t1_stall_n1", stall, 1'b1);
    idle();
    key_a = 128'h44444444_33333333_22222222_11111111;
    check("t1_key_n2", key, key_a);
    check("t1_valid_n2", valid, 1'b0);
    check("t1_stall_n2", stall, 1'b1);
    idle();
    check("t1_valid_n3", valid, 1'b1);
    check("t1_stall_n3", stall, 1'b0);
    check("t1_mask", rdata[5:2], 4'h0);

    // Incomplete commit
    wr(3'd0, 32'hA0A0A0A0); wr(3'd2, 32'hC2C2C2C2);
    wr(3'd4, C_COMMIT);
    check("t2_err", rdata[7:6], 2'd1);
    check("t2_key_err", kerr, 1'b1);
    check("t2_state", rdata[10:8], 3'd3);
    check("t2_stall", stall, 1'b0);
    check("t2_key_kept", key, key_a);
    wr(3'd4, C_CLR_ERR);
    check("t2_err_cleared", rdata[7:6], 2'd0);

    // Drain with busy high for 10 cycles
    wr(3'd1, 32'hB1B1B1B1); wr(3'd3, 32'hD3D3D3D3);
    key_b = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
    busy = 1'b1;
    wr(3'd4, C_COMMIT);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("t3_old_key", key, key_a);
      check("t3_old_valid", valid, 1'b1);
    end
    busy = 1'b0;
    idle();
    check("t3_swap_key", key, key_b);
    idle();

    // Drain timeout
    load4($urandom, $urandom, $urandom, $urandom);
    busy = 1'b1;
    wr(3'd4, C_COMMIT);
    n = 0;
    while (rdata[10:8] != 3'd4 && n < 200) begin idle(); n++; end
    check("t3_timeout_cycles", n, TO);
    check("t3_timeout_err", rdata[7:6], 2'd2);
    check("t3_timeout_key", key, 128'h0);
    busy = 1'b0;
    wr(3'd4, C_CLR_ERR);

    // Fault in the same cycle as a commit
    load4(32'h1, 32'h2, 32'h3, 32'h4);
    cyc(1'b0, 1'b1, 3'd4, C_COMMIT, 1'b1);
    check("t4_state", rdata[10:8], 3'd4);
    check("t4_err", rdata[7:6], 2'd3);
    wr(3'd1, 32'hDEADBEEF);
    idle();
    check("t4_mask_err", rdata[5:2], 4'h0);
    wr(3'd4, C_CLR_ERR);
    check("t4_idle", rdata[10:8], 3'd0);
    check("t4_mask_idle", rdata[5:2], 4'h0);

    // Clear in ACTIVE, then reset mid-drain
    load4(32'h5, 32'h6, 32'h7, 32'h8);
    wr(3'd4, C_COMMIT); idle(); idle();
    wr(3'd4, C_CLEAR);
    check("t5_clear_state", rdata[10:8], 3'd0);
    check("t5_clear_key", key, 128'h0);
    check("t5_clear_valid", valid, 1'b0);
    load4(32'h9, 32'hA, 32'hB, 32'hC);
    busy = 1'b1;
    wr(3'd4, C_COMMIT); idle(); idle();
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 1'b0);
    check("t5_rst_status", rdata, 32'h0);
    check("t5_rst_key", key, 128'h0);
    check("t5_rst_stall", stall, 1'b0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, w, e;
      logic [2:0] a;
      logic [31:0] d;
      int sel;
      if ($urandom_range(0, 7) == 0) busy = ~busy;
      r   = ($urandom_range(0, 299) == 0);
      e   = ($urandom_range(0, 79) == 0);
      w   = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 5)      a = 3'(sel % 4);
      else if (sel < 9) a = 3'd4;
      else              a = 3'($urandom_range(5, 7));
      d = $urandom;
      if (a == 3'd4) begin
        d[0] = ($urandom_range(0, 9) < 7);
        d[1] = ($urandom_range(0, 9) == 0);
        d[2] = ($urandom_range(0, 9) < 3);
      end
      cyc(r, w, a, d, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
